mem_wb_stage: RTL and testbench

MEM/WB pipeline latch plus write-back logic for the MIPS-DLX core, directly downstream of the data-memory stage. It registers the MEM-stage results, aligns and extends raw block-RAM read data for sub-word loads, and selects the register-file write data. Data memory has one cycle of registered read latency, so RAM read data enters this block unregistered in the WB cycle. A hold register keeps load data stable across stalls.

---
 rtl/mem_wb_stage.sv | 117 +++++++++++
 tb/tb_mem_wb_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline latch and write-back select for the DLX core: registers MEM results,
// aligns big-endian sub-word loads from raw RAM data and keeps load data stable across stalls.
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [1:0]            WB_control,
  input  logic [2:0]            load_type,
  input  logic [DATA_W-1:0]     data_from_ALU,
  input  logic [REG_ADDR_W-1:0] reg_write_in,
  input  logic [DATA_W-1:0]     data_from_mem,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_reg_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  load_misaligned
);

  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  logic                  valid_r;
  logic [1:0]            wbc_r;
  logic [2:0]            ltype_r;
  logic [DATA_W-1:0]     alu_r;
  logic [REG_ADDR_W-1:0] rd_r;
  logic [DATA_W-1:0]     hold_data;
  logic                  hold_valid;

  logic [DATA_W-1:0]     mem_word;
  logic [DATA_W-1:0]     load_word;
  logic                  mis;

  function automatic logic [DATA_W-1:0] extract_load(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        off,
    input logic [2:0]        lt
  );
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [DATA_W-1:0]  res;
    case (off)
      2'd0:    byte_s = word[31:24];
      2'd1:    byte_s = word[23:16];
      2'd2:    byte_s = word[15:8];
      default: byte_s = word[7:0];
    endcase
    half_s = off[1] ? word[15:0] : word[31:16];
    case (lt)
      LT_LB:   res = {{(DATA_W-8){byte_s[7]}}, byte_s};
      LT_LBU:  res = {{(DATA_W-8){1'b0}}, byte_s};
      LT_LH:   res = {{(DATA_W-16){half_s[15]}}, half_s};
      LT_LHU:  res = {{(DATA_W-16){1'b0}}, half_s};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] lt);
    logic m;
    case (lt)
      LT_LB, LT_LBU: m = 1'b0;
      LT_LH, LT_LHU: m = off[0];
      default:       m = (off != 2'd0);
    endcase
    return m;
  endfunction

  // ---- MEM -> WB register stage ----
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r    <= 1'b0;
      wbc_r      <= 2'b00;
      ltype_r    <= 3'b000;
      alu_r      <= '0;
      rd_r       <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (flush) begin
      valid_r    <= 1'b0;
      wbc_r      <= 2'b00;
      hold_valid <= 1'b0;
    end else if (stall) begin
      // Capture RAM data only on the first stalled edge; it is what WB already saw.
      if (!hold_valid) begin
        hold_data  <= data_from_mem;
        hold_valid <= 1'b1;
      end
    end else begin
      valid_r    <= valid_in;
      wbc_r      <= WB_control;
      ltype_r    <= load_type;
      alu_r      <= data_from_ALU;
      rd_r       <= reg_write_in;
      hold_valid <= 1'b0;
    end
  end

  // ---- WB combinational select ----
  assign mem_word  = hold_valid ? hold_data : data_from_mem;
  assign load_word = extract_load(mem_word, alu_r[1:0], ltype_r);
  assign mis       = is_misaligned(alu_r[1:0], ltype_r);

  assign load_misaligned = valid_r & wbc_r[1] & mis;
  assign wb_data         = wbc_r[1] ? load_word : alu_r;
  assign wb_reg_write    = valid_r & wbc_r[0] & ~stall & (rd_r != '0) & ~load_misaligned;
  assign wb_reg_addr     = rd_r;
  assign wb_valid        = valid_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table for single-cycle behaviour plus
// hand-written stall, flush and reset sequences.
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        reset, stall, flush, valid_in;
  logic [1:0]  WB_control;
  logic [2:0]  load_type;
  logic [31:0] data_from_ALU, data_from_mem;
  logic [4:0]  reg_write_in;
  logic        wb_valid, wb_reg_write, load_misaligned;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .WB_control(WB_control), .load_type(load_type), .data_from_ALU(data_from_ALU),
    .reg_write_in(reg_write_in), .data_from_mem(data_from_mem),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_reg_addr(wb_reg_addr),
    .wb_data(wb_data), .load_misaligned(load_misaligned)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        vin;
    logic [1:0]  wbc;
    logic [2:0]  lt;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] mem;
    logic        e_vld;
    logic        e_rw;
    logic [31:0] e_data;
    logic        e_mis;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic drive(input logic vin, input logic [1:0] wbc, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [4:0] rd, input logic [31:0] mem);
    valid_in      = vin;
    WB_control    = wbc;
    load_type     = lt;
    data_from_ALU = alu;
    reg_write_in  = rd;
    data_from_mem = mem;
  endtask

  initial begin
    vecs[0]  = '{"alu_r7",     1'b1, 2'b01, 3'd0, 32'h12345678, 5'd7,  32'h0,        1'b1, 1'b1, 32'h12345678, 1'b0};
    vecs[1]  = '{"alu_r0",     1'b1, 2'b01, 3'd0, 32'h12345678, 5'd0,  32'h0,        1'b1, 1'b0, 32'h12345678, 1'b0};
    vecs[2]  = '{"lb_off3",    1'b1, 2'b11, 3'd3, 32'h00000103, 5'd3,  32'h11223380, 1'b1, 1'b1, 32'hFFFFFF80, 1'b0};
    vecs[3]  = '{"lbu_off3",   1'b1, 2'b11, 3'd4, 32'h00000103, 5'd3,  32'h11223380, 1'b1, 1'b1, 32'h00000080, 1'b0};
    vecs[4]  = '{"lb_off0",    1'b1, 2'b11, 3'd3, 32'h00000100, 5'd4,  32'h11223380, 1'b1, 1'b1, 32'h00000011, 1'b0};
    vecs[5]  = '{"lb_off1",    1'b1, 2'b11, 3'd3, 32'h00000101, 5'd4,  32'h11223380, 1'b1, 1'b1, 32'h00000022, 1'b0};
    vecs[6]  = '{"lb_off2",    1'b1, 2'b11, 3'd3, 32'h00000102, 5'd4,  32'h11223380, 1'b1, 1'b1, 32'h00000033, 1'b0};
    vecs[7]  = '{"lh_off2",    1'b1, 2'b11, 3'd1, 32'h00000102, 5'd5,  32'h11228001, 1'b1, 1'b1, 32'hFFFF8001, 1'b0};
    vecs[8]  = '{"lhu_off2",   1'b1, 2'b11, 3'd2, 32'h00000102, 5'd5,  32'h11228001, 1'b1, 1'b1, 32'h00008001, 1'b0};
    vecs[9]  = '{"lh_off0",    1'b1, 2'b11, 3'd1, 32'h00000100, 5'd6,  32'h80017FFF, 1'b1, 1'b1, 32'hFFFF8001, 1'b0};
    vecs[10] = '{"lhu_off0",   1'b1, 2'b11, 3'd2, 32'h00000100, 5'd6,  32'h80017FFF, 1'b1, 1'b1, 32'h00008001, 1'b0};
    vecs[11] = '{"lw_mis",     1'b1, 2'b11, 3'd0, 32'h00000102, 5'd8,  32'h11223380, 1'b1, 1'b0, 32'h11223380, 1'b1};
    vecs[12] = '{"lh_mis",     1'b1, 2'b11, 3'd1, 32'h00000101, 5'd8,  32'h11228001, 1'b1, 1'b0, 32'h00001122, 1'b1};
    vecs[13] = '{"lw_ok",      1'b1, 2'b11, 3'd0, 32'h00000200, 5'd31, 32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[14] = '{"lt7_as_lw",  1'b1, 2'b11, 3'd7, 32'h00000204, 5'd2,  32'hA5A5A5A5, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0};
    vecs[15] = '{"store",      1'b1, 2'b00, 3'd0, 32'h00000400, 5'd9,  32'h0BADF00D, 1'b1, 1'b0, 32'h00000400, 1'b0};
    vecs[16] = '{"invalid",    1'b0, 2'b11, 3'd0, 32'h00000102, 5'd5,  32'h11223380, 1'b0, 1'b0, 32'h11223380, 1'b0};
    vecs[17] = '{"lb_no_wr",   1'b1, 2'b10, 3'd3, 32'h00000103, 5'd5,  32'h11223380, 1'b1, 1'b0, 32'hFFFFFF80, 1'b0};

    // Reset held two cycles with every input nonzero
    reset = 1'b1; stall = 1'b1; flush = 1'b1;
    drive(1'b1, 2'b11, 3'd3, 32'hFFFFFFFF, 5'd31, 32'hFFFFFFFF);
    repeat (2) @(negedge clock);
    chk("rst_valid", wb_valid, 1'b0);
    chk("rst_rw",    wb_reg_write, 1'b0);
    chk("rst_data",  wb_data, 32'h0);
    chk("rst_addr",  wb_reg_addr, 5'd0);
    chk("rst_mis",   load_misaligned, 1'b0);
    reset = 1'b0; stall = 1'b0; flush = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].vin, vecs[i].wbc, vecs[i].lt, vecs[i].alu, vecs[i].rd, vecs[i].mem);
      @(negedge clock);
      chk({vecs[i].name, "_valid"}, wb_valid, vecs[i].e_vld);
      chk({vecs[i].name, "_rw"},    wb_reg_write, vecs[i].e_rw);
      chk({vecs[i].name, "_addr"},  wb_reg_addr, vecs[i].rd);
      chk({vecs[i].name, "_data"},  wb_data, vecs[i].e_data);
      chk({vecs[i].name, "_mis"},   load_misaligned, vecs[i].e_mis);
    end

    // Stall: load data seen in the first WB cycle must survive RAM data changes
    drive(1'b1, 2'b11, 3'd0, 32'h00000300, 5'd9, 32'hCAFEF00D);
    @(negedge clock);
    stall = 1'b1;
    drive(1'b1, 2'b01, 3'd0, 32'h77777777, 5'd12, 32'hCAFEF00D);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_rw",   wb_reg_write, 1'b0);
      chk("stall_data", wb_data, 32'hCAFEF00D);
      chk("stall_addr", wb_reg_addr, 5'd9);
      @(negedge clock);
      data_from_mem = 32'hDEADBEEF;
    end
    stall = 1'b0;
    drive(1'b0, 2'b00, 3'd0, 32'h0, 5'd0, 32'hDEADBEEF);
    #1;
    chk("release_rw",   wb_reg_write, 1'b1);
    chk("release_data", wb_data, 32'hCAFEF00D);
    @(negedge clock);
    chk("after_release_rw", wb_reg_write, 1'b0);

    // Flush and stall together while hold register is loaded
    drive(1'b1, 2'b11, 3'd0, 32'h00000500, 5'd10, 32'h01020304);
    @(negedge clock);
    stall = 1'b1;
    @(negedge clock);
    chk("pre_flush_hold", dut.hold_valid, 1'b1);
    flush = 1'b1;
    drive(1'b1, 2'b01, 3'd0, 32'h0000ABCD, 5'd11, 32'h55667788);
    @(negedge clock);
    flush = 1'b0; stall = 1'b0;
    #1;
    chk("flush_valid", wb_valid, 1'b0);
    chk("flush_rw",    wb_reg_write, 1'b0);
    chk("flush_hold",  dut.hold_valid, 1'b0);
    drive(1'b1, 2'b11, 3'd0, 32'h00000600, 5'd13, 32'h99AABBCC);
    @(negedge clock);
    chk("post_flush_data", wb_data, 32'h99AABBCC);
    chk("post_flush_rw",   wb_reg_write, 1'b1);

    // Reset in the middle of a stall drops the held load
    stall = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_valid", wb_valid, 1'b0);
    chk("midrst_hold",  dut.hold_valid, 1'b0);
    chk("midrst_data",  wb_data, 32'h0);
    reset = 1'b0; stall = 1'b0;
    drive(1'b0, 2'b00, 3'd0, 32'h0, 5'd0, 32'h0);
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
